imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the single-format branch immediate generator. Decodes the instruction format from the opcode and produces the sign-extended immediate for all RV32I/RV64I base formats (I, S, B, U, J), plus a format code and an illegal flag. Sits between fetch/decode and the ALU operand mux. Uses a valid/ready handshake with a sideband tag, so it tolerates stalls and flushes.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
TAG_W, 32, sideband tag width (typically PC), passed through unchanged.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush
in_valid  input  1  instruction valid
in_ready  output  1  block can accept this cycle
in_instr  input  32  instruction word
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_imm  output  XLEN  sign-extended immediate
out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
out_illegal  output  1  opcode not in the supported set
out_tag  output  TAG_W  tag of the result

Behaviour:
- One clock domain; reset is asynchronous and active-low (rst_n); all state clears immediately on assertion.
- Reset values: out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, all internal valids 0. in_ready is 1 once rst_n is high.
- Two stages:
  - S1 registers the instruction and tag, and decodes the format.
  - S2 registers imm, fmt, illegal and tag; S2 drives the outputs.
- Latency: 2 cycles from the in_valid&&in_ready edge to out_valid, with no backpressure. Throughput is 1 per cycle.
- Advance rules:
  - S2 loads when !s2_valid || out_ready.
  - S1 advances into S2 when S2 loads.
  - in_ready = !flush && (!s1_valid || S2 loads).
- Holding stages keep all fields stable; outputs do not change while out_valid && !out_ready.
- Opcode map:
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - Anything else: fmt=0, imm=0, illegal=1.
- Immediates before extension:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- Extension: every immediate is sign-extended from instr[31] to XLEN. U-type at XLEN=64 extends from bit 31.
- Flush: both valids clear at the next edge and in_valid is ignored that cycle. Flush wins over a simultaneous accept or a simultaneous output handshake (the handshake still completes if out_ready was high).
- Reset mid-operation: in-flight entries are discarded with no output pulse.
- Ordering: strictly FIFO; no entry is dropped or duplicated under any out_ready pattern.

Optional Feature:
Macro IMM_GEN_SHAMT_EN.
- Defined: for opcode 0010011 with funct3 001 or 101, out_imm is instr[25:20] zero-extended when XLEN=64, and instr[24:20] zero-extended when XLEN=32. funct7/funct6 bits are removed; fmt stays 1.
- Undefined: shifts are treated as plain I-type (instr[31:20] sign-extended).

Test Plan:
- Reset with rst_n=0 mid-stream, 2 entries in flight -> out_valid=0 immediately; no stale output after release; in_ready=1.
- addi x1,x0,-1 (0xFFF00093), out_ready=1 -> 2 cycles later out_imm=0xFFFFFFFF, fmt=1, illegal=0, out_tag=input tag.
- beq x0,x0,-4 (0xFE000EE3) -> out_imm=0xFFFFFFFC, fmt=3. lui x5,0x12345 (0x123452B7) -> 0x12345000, fmt=4. XLEN=64 lui 0x80000 (0x800002B7) -> 0xFFFFFFFF80000000.
- Stream 4 back-to-back instrs with out_ready held 0 for 5 cycles -> exactly 2 accepted, then in_ready=0 and outputs stable. Release out_ready -> all 4 emerge in order with correct tags.
- 0x0000007F -> out_imm=0, fmt=0, illegal=1. Flush asserted with S1 and S2 full and in_valid=1 -> next cycle out_valid=0, and nothing from before the flush ever appears.
- srai x1,x1,3 (0x4030D093) -> IMM_GEN_SHAMT_EN defined: out_imm=3. Undefined: out_imm=0x403.

Source files
------------

// File: rtl/imm_gen_if.sv
// Handshake bundle between decode, the immediate generator and the ALU operand mux.
// The slave modport is the generator's view; the master modport is its environment's view.
interface imm_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Two-stage RV32I/RV64I immediate generator with valid/ready handshake and tag passthrough.
// Optional macro IMM_GEN_SHAMT_EN: shift-immediate ops return only the zero-extended shamt.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    imm_gen_if.slave  bus
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    function automatic logic [2:0] decode_fmt(input logic [6:0] opc);
        logic [2:0] fmt;
        case (opc)
            7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
            7'b0100011:                         fmt = FMT_S;
            7'b1100011:                         fmt = FMT_B;
            7'b0110111, 7'b0010111:             fmt = FMT_U;
            7'b1101111:                         fmt = FMT_J;
            default:                            fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    logic             s1_valid_reg;
    logic [31:0]      s1_instr_reg;
    logic [TAG_W-1:0] s1_tag_reg;
    logic [2:0]       s1_fmt_reg;

    logic             s2_valid_reg;
    logic [XLEN-1:0]  s2_imm_reg;
    logic [2:0]       s2_fmt_reg;
    logic             s2_illegal_reg;
    logic [TAG_W-1:0] s2_tag_reg;

    logic             s2_load;
    logic             in_ready;
    logic [31:0]      ins;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  imm_next;

    assign s2_load  = !s2_valid_reg || bus.out_ready;
    assign in_ready = !flush && (!s1_valid_reg || s2_load);
    assign ins      = s1_instr_reg;

    // Every format places the sign in instr[31], so a 32-bit image sign-extends cleanly to XLEN.
    always_comb begin
        imm32    = '0;
        imm_next = '0;
        case (s1_fmt_reg)
            FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm32 = {ins[31:12], 12'b0};
            FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_next = XLEN'($signed(imm32));
`ifdef IMM_GEN_SHAMT_EN
        if (ins[6:0] == 7'b0010011 && ins[13:12] == 2'b01) begin
            imm_next = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_instr_reg   <= '0;
            s1_tag_reg     <= '0;
            s1_fmt_reg     <= FMT_NONE;
            s2_valid_reg   <= 1'b0;
            s2_imm_reg     <= '0;
            s2_fmt_reg     <= FMT_NONE;
            s2_illegal_reg <= 1'b0;
            s2_tag_reg     <= '0;
        end else if (flush) begin
            // Only the valids drop; a concurrent out_ready handshake still counts downstream.
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_imm_reg     <= imm_next;
                    s2_fmt_reg     <= s1_fmt_reg;
                    s2_illegal_reg <= (s1_fmt_reg == FMT_NONE);
                    s2_tag_reg     <= s1_tag_reg;
                end
            end
            if (in_ready) begin
                s1_valid_reg <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_instr_reg <= bus.in_instr;
                    s1_tag_reg   <= bus.in_tag;
                    s1_fmt_reg   <= decode_fmt(bus.in_instr[6:0]);
                end
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = s2_valid_reg;
    assign bus.out_imm     = s2_imm_reg;
    assign bus.out_fmt     = s2_fmt_reg;
    assign bus.out_illegal = s2_illegal_reg;
    assign bus.out_tag     = s2_tag_reg;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream and are
// checked every cycle against a FIFO-of-instructions model with a 2-cycle visibility delay.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int now = 0;
    bit last_acc = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] tag;
        int          t;
    } ent_t;
    ent_t q[$];

    imm_gen_if #(.XLEN(32), .TAG_W(32)) if32 ();
    imm_gen_if #(.XLEN(64), .TAG_W(32)) if64 ();

    assign if32.in_valid  = in_valid;
    assign if32.in_instr  = in_instr;
    assign if32.in_tag    = in_tag;
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.in_instr  = in_instr;
    assign if64.in_tag    = in_tag;
    assign if64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64));

    always #5 clk = ~clk;

    function automatic int ref_fmt(input logic [31:0] i);
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: return 1;
            7'b0100011:                         return 2;
            7'b1100011:                         return 3;
            7'b0110111, 7'b0010111:             return 4;
            7'b1101111:                         return 5;
            default:                            return 0;
        endcase
    endfunction

    // Value of the immediate as a signed integer, then viewed at 64 bits.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input bit x64);
        longint v;
        case (ref_fmt(i))
            1: v = longint'($signed(i[31:20]));
            2: v = longint'($signed({i[31:25], i[11:7]}));
            3: v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            4: v = longint'($signed({i[31:12], 12'h000}));
            5: v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: v = 0;
        endcase
`ifdef IMM_GEN_SHAMT_EN
        if (i[6:0] == 7'b0010011 && (i[14:12] == 3'b001 || i[14:12] == 3'b101))
            v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
`endif
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Sample at the falling edge, update the model, then return 1 time unit past the next rising edge.
    task automatic step();
        bit          exp_v, s1_full, exp_rdy;
        logic [63:0] r32, r64;
        ent_t        e;
        @(negedge clk);
        now++;
        last_acc = 0;
        if (!rst_n) begin
            chk("rst_out_valid32", if32.out_valid, 0);
            chk("rst_out_valid64", if64.out_valid, 0);
            q.delete();
        end else begin
            exp_v   = (q.size() > 0) && (q[0].t <= now - 2);
            s1_full = (q.size() == 2) || (q.size() == 1 && !exp_v);
            exp_rdy = !flush && (!s1_full || !exp_v || out_ready);
            chk("out_valid32", if32.out_valid, exp_v);
            chk("out_valid64", if64.out_valid, exp_v);
            chk("in_ready32", if32.in_ready, exp_rdy);
            chk("in_ready64", if64.in_ready, exp_rdy);
            if (exp_v && if32.out_valid && if64.out_valid) begin
                e   = q[0];
                r32 = ref_imm(e.instr, 1'b0);
                r64 = ref_imm(e.instr, 1'b1);
                chk("imm32", if32.out_imm, {32'h0, r32[31:0]});
                chk("imm64", if64.out_imm, r64);
                chk("fmt32", if32.out_fmt, ref_fmt(e.instr));
                chk("fmt64", if64.out_fmt, ref_fmt(e.instr));
                chk("illegal32", if32.out_illegal, ref_fmt(e.instr) == 0);
                chk("illegal64", if64.out_illegal, ref_fmt(e.instr) == 0);
                chk("tag32", if32.out_tag, e.tag);
                chk("tag64", if64.out_tag, e.tag);
                if (out_ready)
                    $display("xfer instr=%h tag=%h imm64=%h fmt=%0d", e.instr, e.tag, if64.out_imm, if64.out_fmt);
            end
            if (exp_v && out_ready) void'(q.pop_front());
            last_acc = in_valid && exp_rdy;
            if (flush) q.delete();
            else if (last_acc) q.push_back('{instr: in_instr, tag: in_tag, t: now});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] tg);
        bit got;
        got = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_tag   = tg;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            got = last_acc;
        end
        chk("send_accept", got, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) step();
    endtask

    logic [31:0] list [4];
    logic [6:0]  opcs [7];
    logic [31:0] r;
    logic [63:0] m;
    int          idx;

    initial begin
        list[0] = 32'h123452B7; list[1] = 32'hFE000EE3;
        list[2] = 32'h0000007F; list[3] = 32'h4030D093;
        opcs[0] = 7'b0010011; opcs[1] = 7'b0000011; opcs[2] = 7'b1100111; opcs[3] = 7'b0100011;
        opcs[4] = 7'b1100011; opcs[5] = 7'b0110111; opcs[6] = 7'b1101111;

        // Hand-computed values that pin the reference model.
        m = ref_imm(32'hFFF00093, 1'b0); chk("pin_addi", m[31:0], 64'hFFFFFFFF);
        m = ref_imm(32'hFE000EE3, 1'b0); chk("pin_beq", m[31:0], 64'hFFFFFFFC);
        m = ref_imm(32'h123452B7, 1'b0); chk("pin_lui", m[31:0], 64'h12345000);
        m = ref_imm(32'h800002B7, 1'b1); chk("pin_lui64", m, 64'hFFFFFFFF80000000);
        m = ref_imm(32'h0000007F, 1'b1); chk("pin_bad_imm", m, 64'h0);
        chk("pin_bad_fmt", ref_fmt(32'h0000007F), 0);
        m = ref_imm(32'h4030D093, 1'b0);
`ifdef IMM_GEN_SHAMT_EN
        chk("pin_srai", m[31:0], 64'h3);
`else
        chk("pin_srai", m[31:0], 64'h403);
`endif

        // Reset state
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", if32.in_ready, 1);
        chk("rst_out_imm", if64.out_imm, 0);
        chk("rst_out_fmt", if32.out_fmt, 0);
        chk("rst_out_illegal", if32.out_illegal, 0);
        chk("rst_out_tag", if32.out_tag, 0);

        // addi x1,x0,-1 with two-cycle latency
        out_ready = 1'b1;
        send(32'hFFF00093, 32'h000000A0);
        step();
        chk("addi_valid", if32.out_valid, 1);
        chk("addi_imm32", if32.out_imm, 64'hFFFFFFFF);
        chk("addi_imm64", if64.out_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("addi_tag", if32.out_tag, 32'hA0);
        send(32'h800002B7, 32'h000000A1);
        drain(4);

        // Back-to-back with downstream stalled: only two fit
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_instr = list[idx];
            in_tag   = 32'h100 + idx;
            step();
            if (last_acc) idx++;
        end
        chk("stall_accepted", idx, 2);
        chk("stall_in_ready", if32.in_ready, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            in_instr = list[idx];
            in_tag   = 32'h100 + idx;
            step();
            if (last_acc) idx++;
        end
        chk("stall_all_sent", idx, 4);
        drain(5);

        // Flush with both stages full and a new instruction offered
        out_ready = 1'b0;
        send(32'h00500113, 32'h200);
        send(32'h00A00193, 32'h201);
        in_valid = 1'b1;
        in_instr = 32'h00F00213;
        in_tag   = 32'h202;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("flush_out_valid", if32.out_valid, 0);
        drain(4);

        // Asynchronous reset with two entries in flight
        out_ready = 1'b0;
        send(32'h00100093, 32'h300);
        send(32'h00200093, 32'h301);
        step();
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", if32.out_valid, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", if64.in_ready, 1);
        drain(4);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            r = $urandom();
            if ($urandom_range(0, 9) != 0) in_instr = {r[31:7], opcs[$urandom_range(0, 6)]};
            else                           in_instr = r;
            in_tag = $urandom();
            step();
        end
        flush = 1'b0;
        drain(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
